// File: rtl/suspi_pkg.sv
// suspi_pkg: types and constants shared by the suspi command receiver.
//   pkt_state_e : packet-level FSM states (one step per received frame)
//   bit_state_e : frame-level FSM states (one step per sampled bit)
//   ERR_*       : err_code values reported with pkt_err
//   DEFAULT_MARKER : default first byte of every packet
package suspi_pkg;

  typedef enum logic [2:0] {
    PK_MARK,
    PK_FLAG,
    PK_LEN_H,
    PK_LEN_L,
    PK_PAYLOAD,
    PK_CRC_H,
    PK_CRC_L
  } pkt_state_e;

  typedef enum logic [2:0] {
    BS_IDLE,
    BS_START,
    BS_DATA,
    BS_PARITY,
    BS_STOP
  } bit_state_e;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_PARITY  = 3'd1;
  localparam logic [2:0] ERR_FRAME   = 3'd2;
  localparam logic [2:0] ERR_LEN     = 3'd3;
  localparam logic [2:0] ERR_CRC     = 3'd4;
  localparam logic [2:0] ERR_TIMEOUT = 3'd5;

  localparam logic [7:0] DEFAULT_MARKER = 8'hA5;

endpackage

// File: rtl/crc16.sv
// crc16: combinational one-byte CRC-16 update (poly 0x1021, MSB first).
//   crc_i  : running CRC before this byte
//   data_i : byte to fold in
//   crc_o  : running CRC after this byte
module crc16 (
  input  logic [15:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);

  always_comb begin
    logic [15:0] c;
    c = crc_i ^ {data_i, 8'h00};
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    crc_o = c;
  end

endmodule

// File: rtl/suspi_cmd_rx.sv
// suspi_cmd_rx: redundant-line oversampled serial command packet receiver.
//   bb_clk_in/rst_h : clock, synchronous active-high reset
//   sample_stb      : oversampling strobe (OVERSAMPLE per bit period)
//   com             : N_CH idle-high serial lines; the first to start is locked
//   byte_valid/byte_data : payload byte stream
//   hdr_valid/flag/length : accepted header (flag/length held)
//   pkt_ok/pkt_err/err_code : packet completion status
//   busy/active_ch  : packet in progress, index of locked line
module suspi_cmd_rx
  import suspi_pkg::*;
#(
  parameter int unsigned N_CH         = 2,
  parameter int unsigned OVERSAMPLE   = 4,
  parameter bit          PARITY_ODD   = 1'b1,
  parameter logic [7:0]  MARKER       = DEFAULT_MARKER,
  parameter int unsigned MAX_LEN      = 2032,
  parameter int unsigned TIMEOUT_BITS = 32,
  localparam int unsigned CHW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            bb_clk_in,
  input  logic            rst_h,
  input  logic            sample_stb,
  input  logic [N_CH-1:0] com,
  output logic            byte_valid,
  output logic [7:0]      byte_data,
  output logic            hdr_valid,
  output logic [7:0]      flag,
  output logic [15:0]     length,
  output logic            pkt_ok,
  output logic            pkt_err,
  output logic [2:0]      err_code,
  output logic            busy,
  output logic [CHW-1:0]  active_ch
);

  localparam int unsigned HALF   = OVERSAMPLE / 2;
  localparam int unsigned TO_STB = TIMEOUT_BITS * OVERSAMPLE;
  localparam int unsigned TOW    = $clog2(TO_STB + 1);

  logic [N_CH-1:0] sync1_q, sync2_q;
  bit_state_e      bit_q;
  pkt_state_e      pkt_q;
  logic [4:0]      stb_cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic            par_q;
  logic [TOW-1:0]  to_cnt_q;
  logic [15:0]     crc_q, crc_d, crc_seed_d;
  logic [7:0]      flag_tmp_q, len_h_q, crc_h_q;
  logic [15:0]     remain_q;
  logic            busy_q, byte_valid_q, hdr_valid_q, pkt_ok_q, pkt_err_q;
  logic [CHW-1:0]  active_ch_q;
  logic [7:0]      byte_data_q, flag_q;
  logic [15:0]     length_q;
  logic [2:0]      err_code_q;

  logic            lock_hit_d, line_d, par_exp_d;
  logic [CHW-1:0]  lock_idx_d;
  logic [15:0]     len_rx_d;

  // Lowest-index low line wins the lock: scan high to low so the last hit sticks.
  always_comb begin
    lock_hit_d = 1'b0;
    lock_idx_d = '0;
    for (int unsigned i = N_CH; i > 0; i--) begin
      if (!sync2_q[i-1]) begin
        lock_hit_d = 1'b1;
        lock_idx_d = CHW'(i - 1);
      end
    end
    line_d     = sync2_q[active_ch_q];
    par_exp_d  = PARITY_ODD ? ~^shift_q : ^shift_q;
    len_rx_d   = {len_h_q, shift_q};
    // The marker byte always starts a fresh CRC, so crc_q need not be re-seeded.
    crc_seed_d = (pkt_q == PK_MARK) ? 16'hFFFF : crc_q;
  end

  crc16 u_crc16 (
    .crc_i  (crc_seed_d),
    .data_i (shift_q),
    .crc_o  (crc_d)
  );

  always_ff @(posedge bb_clk_in) begin
    if (rst_h) begin
      sync1_q      <= '1;
      sync2_q      <= '1;
      bit_q        <= BS_IDLE;
      pkt_q        <= PK_MARK;
      stb_cnt_q    <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      to_cnt_q     <= '0;
      crc_q        <= '0;
      flag_tmp_q   <= '0;
      len_h_q      <= '0;
      crc_h_q      <= '0;
      remain_q     <= '0;
      busy_q       <= 1'b0;
      active_ch_q  <= '0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= '0;
      hdr_valid_q  <= 1'b0;
      flag_q       <= '0;
      length_q     <= '0;
      pkt_ok_q     <= 1'b0;
      pkt_err_q    <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      sync1_q      <= com;
      sync2_q      <= sync1_q;
      byte_valid_q <= 1'b0;
      hdr_valid_q  <= 1'b0;
      pkt_ok_q     <= 1'b0;
      pkt_err_q    <= 1'b0;
      if (sample_stb) begin
        case (bit_q)
          BS_IDLE: begin
            if (!busy_q) begin
              if (lock_hit_d) begin
                active_ch_q <= lock_idx_d;
                busy_q      <= 1'b1;
                bit_q       <= BS_START;
                stb_cnt_q   <= '0;
              end
            end else if (!line_d) begin
              bit_q     <= BS_START;
              stb_cnt_q <= '0;
            end else if (to_cnt_q == TOW'(TO_STB - 1)) begin
              pkt_err_q  <= 1'b1;
              err_code_q <= ERR_TIMEOUT;
              pkt_q      <= PK_MARK;
              busy_q     <= 1'b0;
            end else begin
              to_cnt_q <= to_cnt_q + 1'b1;
            end
          end
          BS_START: begin
            if (stb_cnt_q == 5'(HALF - 1)) begin
              if (line_d) begin
                bit_q <= BS_IDLE;
                if (pkt_q == PK_MARK) busy_q <= 1'b0;
              end else begin
                bit_q     <= BS_DATA;
                stb_cnt_q <= '0;
                bit_idx_q <= '0;
              end
            end else begin
              stb_cnt_q <= stb_cnt_q + 1'b1;
            end
          end
          BS_DATA, BS_PARITY, BS_STOP: begin
            if (stb_cnt_q != 5'(OVERSAMPLE - 1)) begin
              stb_cnt_q <= stb_cnt_q + 1'b1;
            end else begin
              stb_cnt_q <= '0;
              if (bit_q == BS_DATA) begin
                shift_q   <= {line_d, shift_q[7:1]};
                bit_idx_q <= bit_idx_q + 1'b1;
                if (bit_idx_q == 3'd7) bit_q <= BS_PARITY;
              end else if (bit_q == BS_PARITY) begin
                par_q <= line_d;
                bit_q <= BS_STOP;
              end else begin
                bit_q    <= BS_IDLE;
                to_cnt_q <= '0;
                if (par_q != par_exp_d || !line_d) begin
                  pkt_err_q  <= 1'b1;
                  err_code_q <= (par_q != par_exp_d) ? ERR_PARITY : ERR_FRAME;
                  pkt_q      <= PK_MARK;
                  busy_q     <= 1'b0;
                end else begin
                  case (pkt_q)
                    PK_MARK: begin
                      if (shift_q == MARKER) begin
                        crc_q <= crc_d;
                        pkt_q <= PK_FLAG;
                      end else begin
                        busy_q <= 1'b0;
                      end
                    end
                    PK_FLAG: begin
                      flag_tmp_q <= shift_q;
                      crc_q      <= crc_d;
                      pkt_q      <= PK_LEN_H;
                    end
                    PK_LEN_H: begin
                      len_h_q <= shift_q;
                      crc_q   <= crc_d;
                      pkt_q   <= PK_LEN_L;
                    end
                    PK_LEN_L: begin
                      if (32'(len_rx_d) > MAX_LEN) begin
                        pkt_err_q  <= 1'b1;
                        err_code_q <= ERR_LEN;
                        pkt_q      <= PK_MARK;
                        busy_q     <= 1'b0;
                      end else begin
                        hdr_valid_q <= 1'b1;
                        flag_q      <= flag_tmp_q;
                        length_q    <= len_rx_d;
                        remain_q    <= len_rx_d;
                        crc_q       <= crc_d;
                        pkt_q       <= (len_rx_d == 16'd0) ? PK_CRC_H : PK_PAYLOAD;
                      end
                    end
                    PK_PAYLOAD: begin
                      byte_valid_q <= 1'b1;
                      byte_data_q  <= shift_q;
                      crc_q        <= crc_d;
                      remain_q     <= remain_q - 1'b1;
                      if (remain_q == 16'd1) pkt_q <= PK_CRC_H;
                    end
                    PK_CRC_H: begin
                      crc_h_q <= shift_q;
                      pkt_q   <= PK_CRC_L;
                    end
                    default: begin
                      if ({crc_h_q, shift_q} == crc_q) begin
                        pkt_ok_q <= 1'b1;
                      end else begin
                        pkt_err_q  <= 1'b1;
                        err_code_q <= ERR_CRC;
                      end
                      pkt_q  <= PK_MARK;
                      busy_q <= 1'b0;
                    end
                  endcase
                end
              end
            end
          end
          default: bit_q <= BS_IDLE;
        endcase
      end
    end
  end

  assign byte_valid = byte_valid_q;
  assign byte_data  = byte_data_q;
  assign hdr_valid  = hdr_valid_q;
  assign flag       = flag_q;
  assign length     = length_q;
  assign pkt_ok     = pkt_ok_q;
  assign pkt_err    = pkt_err_q;
  assign err_code   = err_code_q;
  assign busy       = busy_q;
  assign active_ch  = active_ch_q;

endmodule

// File: tb/tb_suspi_cmd_rx.sv
// tb_suspi_cmd_rx: directed + randomized packet bench for suspi_cmd_rx with a
// byte-level reference model (packet rules and a bit-serial CRC-16).
module tb_suspi_cmd_rx;

  localparam int OS     = 4;
  localparam int STBDIV = 3;
  localparam int BITCLK = OS * STBDIV;

  logic        clk = 1'b0;
  logic        rst_h;
  logic        sample_stb = 1'b0;
  logic [1:0]  com;
  logic        byte_valid, hdr_valid, pkt_ok, pkt_err, busy;
  logic [7:0]  byte_data, flag;
  logic [15:0] length;
  logic [2:0]  err_code;
  logic [0:0]  active_ch;

  suspi_cmd_rx #(
    .N_CH(2), .OVERSAMPLE(OS), .PARITY_ODD(1'b1), .MARKER(8'hA5),
    .MAX_LEN(2032), .TIMEOUT_BITS(32)
  ) dut (
    .bb_clk_in(clk), .rst_h(rst_h), .sample_stb(sample_stb), .com(com),
    .byte_valid(byte_valid), .byte_data(byte_data), .hdr_valid(hdr_valid),
    .flag(flag), .length(length), .pkt_ok(pkt_ok), .pkt_err(pkt_err),
    .err_code(err_code), .busy(busy), .active_ch(active_ch)
  );

  always #5 clk = ~clk;

  int stb_div = 0;
  always @(negedge clk) begin
    stb_div    = (stb_div == STBDIV - 1) ? 0 : stb_div + 1;
    sample_stb = (stb_div == 0);
  end

  // Observed events
  logic [7:0] got_bytes[$];
  int hdr_cnt = 0, ok_cnt = 0, err_cnt = 0, both_cnt = 0;
  always @(negedge clk) begin
    if (byte_valid) got_bytes.push_back(byte_data);
    if (hdr_valid) hdr_cnt++;
    if (pkt_ok) ok_cnt++;
    if (pkt_err) err_cnt++;
    if (pkt_ok && pkt_err) both_cnt++;
  end

  // Reference model state
  logic [7:0]  pkt[$];
  logic [7:0]  exp_bytes[$];
  int          exp_hdr, exp_ok, exp_err;
  logic [2:0]  exp_code;
  logic [7:0]  exp_flag;
  logic [15:0] exp_len;

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] crc_of(input int n);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int k = 0; k < n; k++) begin
      for (int b = 7; b >= 0; b--) begin
        logic fb;
        fb = c[15] ^ pkt[k][b];
        c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
    end
    return c;
  endfunction

  // Build marker/flag/length/payload/CRC; seq selects payload 00,01,.. else random
  task automatic make_pkt(input logic [7:0] f, input int len, input bit seq);
    logic [15:0] c;
    pkt.delete();
    pkt.push_back(8'hA5);
    pkt.push_back(f);
    pkt.push_back(8'(len >> 8));
    pkt.push_back(8'(len));
    for (int i = 0; i < len; i++) pkt.push_back(seq ? 8'(i) : 8'($urandom));
    c = crc_of(pkt.size());
    pkt.push_back(c[15:8]);
    pkt.push_back(c[7:0]);
  endtask

  // Expected outcome of sending pkt, with byte index 'flip' carrying bad parity
  task automatic predict(input int flip);
    int len;
    len = 0;
    exp_hdr = 0; exp_ok = 0; exp_err = 0; exp_code = 3'd0;
    exp_flag = 8'h00; exp_len = 16'h0; exp_bytes.delete();
    for (int k = 0; k < pkt.size(); k++) begin
      if (k == flip) begin exp_err = 1; exp_code = 3'd1; return; end
      if (k == 0 && pkt[0] != 8'hA5) return;
      if (k == 3) begin
        len = int'({pkt[2], pkt[3]});
        if (len > 2032) begin exp_err = 1; exp_code = 3'd3; return; end
        exp_hdr = 1; exp_flag = pkt[1]; exp_len = 16'(len);
      end
      if (k >= 4 && k < 4 + len) exp_bytes.push_back(pkt[k]);
      if (k == 5 + len) begin
        if ({pkt[4+len], pkt[5+len]} == crc_of(4 + len)) exp_ok = 1;
        else begin exp_err = 1; exp_code = 3'd4; end
        return;
      end
    end
  endtask

  task automatic idle_bits(input int n);
    repeat (n * BITCLK) @(negedge clk);
  endtask

  task automatic send_byte(input int ch, input logic [7:0] b, input bit badpar, input bit noise);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ badpar, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      com[ch] = fr[i];
      if (noise) com[1] = (i == 0) ? 1'b0 : (i == 10) ? 1'b1 : 1'($urandom);
      idle_bits(1);
    end
  endtask

  task automatic send_packet(input int ch, input int flip, input bit noise, input int nbytes);
    for (int k = 0; k < nbytes; k++) begin
      send_byte(ch, pkt[k], k == flip, noise);
      if (k == flip) break;
      idle_bits($urandom_range(0, 2));
    end
  endtask

  task automatic clear_mon();
    got_bytes.delete();
    hdr_cnt = 0; ok_cnt = 0; err_cnt = 0;
  endtask

  task automatic wait_done(input string tag, input int max_bits);
    int n;
    n = 0;
    while ((ok_cnt + err_cnt) == 0 && n < max_bits * BITCLK) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 32'((ok_cnt + err_cnt) > 0), 32'd1);
  endtask

  task automatic check_result(input string tag);
    check({tag, "_hdr"}, 32'(hdr_cnt), 32'(exp_hdr));
    check({tag, "_ok"}, 32'(ok_cnt), 32'(exp_ok));
    check({tag, "_err"}, 32'(err_cnt), 32'(exp_err));
    check({tag, "_nbytes"}, 32'(got_bytes.size()), 32'(exp_bytes.size()));
    for (int i = 0; i < exp_bytes.size() && i < got_bytes.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(got_bytes[i]), 32'(exp_bytes[i]));
    if (exp_err != 0) check({tag, "_code"}, 32'(err_code), 32'(exp_code));
    if (exp_hdr != 0) begin
      check({tag, "_flag"}, 32'(flag), 32'(exp_flag));
      check({tag, "_len"}, 32'(length), 32'(exp_len));
    end
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int nb;
    bit saw;
    rst_h = 1'b1;
    com   = '1;
    repeat (4) @(negedge clk);
    check("rst_outs", 32'({byte_valid, hdr_valid, pkt_ok, pkt_err, busy}), 32'd0);
    check("rst_flag_len", 32'({flag, length}), 32'd0);
    check("rst_code_ch", 32'({err_code, active_ch}), 32'd0);
    rst_h = 1'b0;
    idle_bits(2);

    // Short glitch: locks, fails start validation, releases silently
    saw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 0) com[0] = 1'b0;
      if (i == 3) com[0] = 1'b1;
      @(negedge clk);
      saw |= busy;
    end
    check("glitch_locked", 32'(saw), 32'd1);
    check("glitch_busy", 32'(busy), 32'd0);
    check("glitch_err", 32'(err_cnt), 32'd0);
    idle_bits(2);

    // Scenario 1: zero-length packet
    clear_mon(); make_pkt(8'h03, 0, 1'b1); predict(-1);
    send_packet(0, -1, 1'b0, pkt.size()); wait_done("s1", 20);
    check_result("s1");
    check("s1_ch", 32'(active_ch), 32'd0);
    idle_bits(3);

    // Scenario 2: 16 sequential payload bytes
    clear_mon(); make_pkt(8'h04, 16, 1'b1); predict(-1);
    send_packet(0, -1, 1'b0, pkt.size()); wait_done("s2", 20);
    check_result("s2");
    idle_bits(3);

    // Scenario 3: parity error on payload byte 5
    clear_mon(); make_pkt(8'h04, 16, 1'b1); predict(9);
    send_packet(0, 9, 1'b0, pkt.size()); wait_done("s3", 20);
    check_result("s3");
    idle_bits(3);

    // Scenario 4: simultaneous start with noise on com[1], then com[1] alone
    clear_mon(); make_pkt(8'($urandom), $urandom_range(1, 6), 1'b0); predict(-1);
    send_packet(0, -1, 1'b1, pkt.size()); wait_done("s4a", 20);
    check_result("s4a");
    check("s4a_ch", 32'(active_ch), 32'd0);
    idle_bits(3);
    clear_mon(); make_pkt(8'($urandom), $urandom_range(1, 6), 1'b0); predict(-1);
    send_packet(1, -1, 1'b0, pkt.size()); wait_done("s4b", 20);
    check_result("s4b");
    check("s4b_ch", 32'(active_ch), 32'd1);
    idle_bits(3);

    // Scenario 5: stray byte, valid packet, oversize length, bad CRC
    clear_mon(); pkt.delete(); pkt.push_back(8'h3C); predict(-1);
    send_packet(0, -1, 1'b0, 1); idle_bits(4);
    check_result("s5_stray");
    clear_mon(); make_pkt(8'($urandom), $urandom_range(1, 8), 1'b0); predict(-1);
    send_packet(0, -1, 1'b0, pkt.size()); wait_done("s5_pkt", 20);
    check_result("s5_pkt");
    idle_bits(3);
    clear_mon(); pkt.delete();
    pkt.push_back(8'hA5); pkt.push_back(8'h07); pkt.push_back(8'h07); pkt.push_back(8'hF1);
    predict(-1);
    send_packet(0, -1, 1'b0, pkt.size()); wait_done("s5_len", 20);
    check_result("s5_len");
    idle_bits(3);
    clear_mon(); make_pkt(8'($urandom), $urandom_range(1, 8), 1'b0);
    pkt[pkt.size()-1] = pkt[pkt.size()-1] ^ 8'h01;
    predict(-1);
    send_packet(0, -1, 1'b0, pkt.size()); wait_done("s5_crc", 20);
    check_result("s5_crc");
    idle_bits(3);

    // Scenario 6: stall after header -> timeout
    clear_mon(); pkt.delete();
    pkt.push_back(8'hA5); pkt.push_back(8'h01); pkt.push_back(8'h00); pkt.push_back(8'h04);
    predict(-1);
    exp_err = 1; exp_code = 3'd5;
    send_packet(0, -1, 1'b0, 4); wait_done("s6_to", 40);
    check_result("s6_to");
    idle_bits(3);

    // Reset in the middle of the fourth payload byte
    clear_mon(); make_pkt(8'h02, 8, 1'b0);
    send_packet(0, -1, 1'b0, 7);
    com[0] = 1'b0; idle_bits(1);
    com[0] = pkt[7][0]; idle_bits(1);
    com[0] = pkt[7][1]; idle_bits(1);
    nb = got_bytes.size();
    check("rstmid_pre_bytes", 32'(nb), 32'd3);
    rst_h = 1'b1; com = '1;
    @(negedge clk);
    check("rstmid_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_h = 1'b0;
    idle_bits(50);
    check("rstmid_bytes", 32'(got_bytes.size()), 32'(nb));
    check("rstmid_okerr", 32'(ok_cnt + err_cnt), 32'd0);
    check("rstmid_flag_len", 32'({flag, length}), 32'd0);
    check("rstmid_busy_end", 32'(busy), 32'd0);

    check("ok_err_exclusive", 32'(both_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/suspi_cmd_rx.md
SUSPI_CMD_RX -- requirements
Module: suspi_cmd_rx

Interface
REQ-001 Parameter N_CH, default 2: number of redundant serial command lines.
REQ-002 Parameter OVERSAMPLE, default 4: sample_stb pulses per bit period; even, range 4..16.
REQ-003 Parameter PARITY_ODD, default 1: 1 selects odd parity, 0 selects even parity.
REQ-004 Parameter MARKER, default 8'hA5: required first byte of every packet.
REQ-005 Parameter MAX_LEN, default 2032: largest accepted payload length.
REQ-006 Parameter TIMEOUT_BITS, default 32: maximum idle gap between bytes inside a packet, in bit periods.
REQ-007 One clock, reset synchronous and active-high, as already decided.
REQ-008 bb_clk_in  in  1  system clock.
REQ-009 rst_h  in  1  synchronous active-high reset.
REQ-010 sample_stb  in  1  one-cycle oversampling strobe.
REQ-011 com  in  N_CH  serial lines; idle high.
REQ-012 byte_valid  out  1  one-cycle pulse: payload byte available.
REQ-013 byte_data  out  8  payload byte; valid while byte_valid is high.
REQ-014 hdr_valid  out  1  one-cycle pulse: header accepted.
REQ-015 flag  out  8  header flag byte; held from hdr_valid until the next packet's hdr_valid.
REQ-016 length  out  16  header length; held like flag.
REQ-017 pkt_ok  out  1  one-cycle pulse: CRC matched.
REQ-018 pkt_err  out  1  one-cycle pulse: packet aborted.
REQ-019 err_code  out  3  error cause; held until the next pkt_err.
REQ-020 busy  out  1  high from start-bit lock until pkt_ok or pkt_err.
REQ-021 active_ch  out  clog2(N_CH) (min 1)  index of the locked line.

Function
REQ-022 Frame format SHALL be 11 bits: start 0, 8 data bits LSB first, parity, stop 1.
REQ-023 Each com bit SHALL pass a 2-flop synchroniser; all sampling SHALL occur only on cycles with sample_stb high.
REQ-024 When busy is low, the lowest-index line sampled low SHALL be locked into active_ch, and busy SHALL rise.
REQ-025 While busy is high, all other lines SHALL be ignored.
REQ-026 Start validation: the locked line is re-sampled OVERSAMPLE/2 strobes after lock.
- High: false start; the bit FSM returns to IDLE and the packet FSM is unchanged.
- On a false start in state MARK, busy SHALL drop.
REQ-027 After a valid start, each later bit SHALL be sampled every OVERSAMPLE strobes.
REQ-028 Bit FSM states SHALL be IDLE, START, DATA (8 bits), PARITY, STOP.
- After STOP is sampled, the bit FSM returns to IDLE and re-arms on the locked line only.
REQ-029 Packet FSM states SHALL be MARK, FLAG, LEN_H, LEN_L, PAYLOAD, CRC_H, CRC_L; each completed frame advances one state.
REQ-030 A MARK byte other than MARKER SHALL be discarded silently.
- busy drops, the lock is released, and the FSM stays in MARK.
- No pkt_err is raised.
REQ-031 hdr_valid SHALL pulse one cycle after the LEN_L stop bit.
- length == 0: PAYLOAD is skipped.
- length > MAX_LEN: err_code 3, and no hdr_valid is issued.
REQ-032 byte_valid SHALL pulse one cycle after each payload stop bit, exactly length times.
- The payload counter is 16-bit and SHALL NOT wrap.
REQ-033 Running CRC: init 16'hFFFF, updated with marker, flag, LEN_H, LEN_L, then each payload byte.
REQ-034 The received CRC is high byte first (CRC_H), then low byte (CRC_L).
- Match: pkt_ok pulses one cycle after the CRC_L stop bit.
- Mismatch: pkt_err pulses with err_code 4.
REQ-035 Per-frame errors, on the stop-bit sample cycle:
- Parity mismatch: err_code 1.
- Stop bit 0: err_code 2.
REQ-036 Inter-byte timeout: if busy and no start is seen within TIMEOUT_BITS*OVERSAMPLE strobes after a stop bit, raise err_code 5.
REQ-037 On any pkt_err, the SHALL response is:
- Packet FSM returns to MARK; busy drops.
- The lock is released on the next cycle.
- No further byte_valid is issued.
REQ-038 pkt_ok and pkt_err SHALL never assert in the same cycle.

Reset
REQ-039 While rst_h is high:
- Both FSMs return to IDLE/MARK; counters and CRC are cleared.
- All pulse outputs, busy, flag, length, err_code and active_ch are 0.
REQ-040 Reset mid-packet SHALL discard the packet with no pkt_err, pkt_ok, or byte_valid pulse.

Structure
REQ-041 Shared package suspi_pkg SHALL hold:
- packet-state and bit-state enums;
- err_code constants: NONE 0, PARITY 1, FRAME 2, LEN 3, CRC 4, TIMEOUT 5;
- the default MARKER.
REQ-042 CRC update SHALL instantiate the existing crc16 sub-module; no other sub-modules.

Verification
REQ-043 Scenario 1, on com[0]:
- Stimulus: A5 03 00 00 + correct CRC.
- Response: hdr_valid with flag=03, length=0; then pkt_ok; active_ch=0; zero byte_valid.
REQ-044 Scenario 2:
- Stimulus: A5 04 00 10, payload 00..0F, correct CRC.
- Response: 16 byte_valid pulses with data 00..0F in order, then pkt_ok.
REQ-045 Scenario 3:
- Stimulus: same packet as scenario 2 with payload byte 5's parity bit flipped.
- Response: pkt_err with err_code=1 at that byte's stop bit; exactly 5 byte_valid pulses.
REQ-046 Scenario 4: simultaneous starts on com[1] and com[0], com[1] carrying noise.
- Response: active_ch=0; packet pkt_ok.
- Follow-up: start on com[1] only; response active_ch=1.
REQ-047 Scenario 5: byte 3C then a valid packet.
- Response: 3C silently discarded with no pkt_err; following packet pkt_ok.
- Follow-up: length 07F1 (>2032); response pkt_err with err_code=3.
REQ-048 Scenario 6:
- Stimulus: header, then stall for 33 bit periods.
- Response: pkt_err with err_code=5.
- Follow-up: rst_h pulsed mid-payload; no pulses; busy=0 next cycle.
